// File: rtl/mips_load_unit_if.sv
// Data-memory read bus for the MIPS load unit.
// Master drives req/addr; slave answers with ack and rdata in the same cycle.
interface mips_load_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mips_load_unit.sv
// Multi-cycle MIPS load path: aligned word fetch, lane extract, sign/zero extend.
// Optional REQ watchdog enabled by defining LOAD_TIMEOUT_EN.
module mips_load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       Addr,
    input  logic [2:0]        Funct,
    output logic              busy,
    output logic              done,
    output logic [1:0]        ErrCode,
    output logic [31:0]       DataOut,
    mips_load_unit_if.master  mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [2:0] FN_LB  = 3'b000;
    localparam logic [2:0] FN_LH  = 3'b001;
    localparam logic [2:0] FN_LW  = 3'b010;
    localparam logic [2:0] FN_LBU = 3'b100;
    localparam logic [2:0] FN_LHU = 3'b101;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : gBadTimeout
        $error("TIMEOUT must be in 2..255");
    end

    state_t      stateQ;
    state_t      stateD;
    logic [31:0] addrQ;
    logic [2:0]  functQ;
    logic [31:0] dataQ;
    logic [1:0]  errQ;
    logic [1:0]  errD;
    logic        accept;
    logic        capture;
    logic        illegal;
    logic        misaligned;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] extracted;

`ifdef LOAD_TIMEOUT_EN
    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);
    logic [7:0] cntQ;
    logic       expired;

    assign expired = (cntQ == LastCnt);
`endif

    // Decode is done on the live inputs; only accepted requests are latched.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        unique case (1'b1)
            (Funct == FN_LB),
            (Funct == FN_LBU): misaligned = 1'b0;
            (Funct == FN_LH),
            (Funct == FN_LHU): misaligned = Addr[0];
            (Funct == FN_LW):  misaligned = (Addr[1:0] != 2'b00);
            default:           illegal    = 1'b1;
        endcase
    end

    always_comb begin
        stateD  = stateQ;
        errD    = errQ;
        accept  = 1'b0;
        capture = 1'b0;
        case (stateQ)
            IDLE: begin
                if (start) begin
                    if (illegal) begin
                        errD   = ERR_FUNCT;
                        stateD = ERR;
                    end else if (misaligned) begin
                        errD   = ERR_ALIGN;
                        stateD = ERR;
                    end else begin
                        accept = 1'b1;
                        stateD = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    capture = 1'b1;
                    stateD  = RESP;
                end
`ifdef LOAD_TIMEOUT_EN
                else if (expired) begin
                    errD   = ERR_TMO;
                    stateD = ERR;
                end
`endif
            end
            RESP:    stateD = IDLE;
            ERR:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        laneByte = 8'h00;
        case (addrQ[1:0])
            2'd0:    laneByte = mem.mem_rdata[31:24];
            2'd1:    laneByte = mem.mem_rdata[23:16];
            2'd2:    laneByte = mem.mem_rdata[15:8];
            default: laneByte = mem.mem_rdata[7:0];
        endcase
        laneHalf = addrQ[1] ? mem.mem_rdata[15:0]
                            : mem.mem_rdata[31:16];
    end

    always_comb begin
        extracted = mem.mem_rdata;
        unique case (1'b1)
            (functQ == FN_LB):
                extracted = {{24{laneByte[7]}}, laneByte};
            (functQ == FN_LBU):
                extracted = {24'h0, laneByte};
            (functQ == FN_LH):
                extracted = {{16{laneHalf[15]}}, laneHalf};
            (functQ == FN_LHU):
                extracted = {16'h0, laneHalf};
            default:
                extracted = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            addrQ  <= 32'h0;
            functQ <= FN_LW;
            dataQ  <= 32'h0;
            errQ   <= ERR_OK;
        end else begin
            stateQ <= stateD;
            errQ   <= errD;
            if (accept) begin
                addrQ  <= Addr;
                functQ <= Funct;
            end
            if (capture) begin
                dataQ <= extracted;
            end
        end
    end

`ifdef LOAD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntQ <= 8'h0;
        end else if (accept) begin
            cntQ <= 8'h0;
        end else if (stateQ == REQ && !mem.mem_ack) begin
            cntQ <= cntQ + 8'h1;
        end
    end
`endif

    assign busy         = (stateQ != IDLE);
    assign done         = (stateQ == RESP) || (stateQ == ERR);
    assign ErrCode      = (stateQ == ERR) ? errQ : ERR_OK;
    assign DataOut      = dataQ;
    assign mem.mem_req  = (stateQ == REQ);
    assign mem.mem_addr = {addrQ[31:2], 2'b00};

endmodule

// File: tb/tb_mips_load_unit.sv
// Directed self-checking bench for mips_load_unit.
// Built with TIMEOUT=4 so the watchdog path is short when enabled.
module tb_mips_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [2:0]  Funct = 3'b010;
    logic        busy;
    logic        done;
    logic [1:0]  ErrCode;
    logic [31:0] DataOut;

    int passCnt = 0;
    int totalCnt = 0;
    int doneCnt = 0;
    int reqCnt = 0;

    mips_load_unit_if memIf ();

    mips_load_unit #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .Addr    (Addr),
        .Funct   (Funct),
        .busy    (busy),
        .done    (done),
        .ErrCode (ErrCode),
        .DataOut (DataOut),
        .mem     (memIf.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) doneCnt++;
        if (memIf.mem_req) reqCnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic runLoad(input string tag,
                           input logic [31:0] a,
                           input logic [2:0] f,
                           input logic [31:0] rd,
                           input int waitCyc,
                           input logic [31:0] exp);
        start = 1'b1;
        Addr  = a;
        Funct = f;
        tick();
        start = 1'b0;
        check({tag, " req"}, 32'(memIf.mem_req), 32'd1);
        check({tag, " addr"}, memIf.mem_addr, {a[31:2], 2'b00});
        repeat (waitCyc) tick();
        memIf.mem_ack   = 1'b1;
        memIf.mem_rdata = rd;
        tick();
        memIf.mem_ack   = 1'b0;
        memIf.mem_rdata = 32'h5A5A_A5A5;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " err"}, 32'(ErrCode), 32'd0);
        check({tag, " data"}, DataOut, exp);
        tick();
        check({tag, " idle"}, 32'(busy | done), 32'd0);
    endtask

    task automatic runErr(input string tag,
                          input logic [31:0] a,
                          input logic [2:0] f,
                          input logic [1:0] code,
                          input logic [31:0] held);
        int reqBase;
        reqBase = reqCnt;
        start = 1'b1;
        Addr  = a;
        Funct = f;
        tick();
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " err"}, 32'(ErrCode), 32'(code));
        check({tag, " data"}, DataOut, held);
        tick();
        check({tag, " idle"}, 32'(busy | done), 32'd0);
        check({tag, " noreq"}, 32'(reqCnt - reqBase), 32'd0);
    endtask

    initial begin
        int doneBase;
        memIf.mem_ack   = 1'b0;
        memIf.mem_rdata = 32'h0;

        tick();
        rst_n = 1'b1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst req", 32'(memIf.mem_req), 32'd0);
        check("rst err", 32'(ErrCode), 32'd0);
        check("rst addr", memIf.mem_addr, 32'h0);
        check("rst data", DataOut, 32'h0);

        runLoad("lw", 32'h0000_1004, 3'b010, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        runLoad("lb1", 32'h0000_1001, 3'b000, 32'h1280_3456, 0, 32'hFFFF_FF80);
        runLoad("lbu1", 32'h0000_1001, 3'b100, 32'h1280_3456, 0, 32'h0000_0080);
        runLoad("lh2", 32'h0000_1002, 3'b001, 32'h1280_3456, 0, 32'h0000_3456);
        runLoad("lb3", 32'h0000_1003, 3'b000, 32'h1280_3456, 1, 32'h0000_0056);
        runLoad("lb0", 32'h0000_1000, 3'b000, 32'h9A80_3456, 0, 32'hFFFF_FF9A);
        runLoad("lh0", 32'h0000_2000, 3'b001, 32'h8001_7FFF, 0, 32'hFFFF_8001);
        runLoad("lhu0", 32'h0000_2000, 3'b101, 32'h8001_7FFF, 2, 32'h0000_8001);
        runLoad("lhu2", 32'h0000_2002, 3'b101, 32'h8001_FFFE, 0, 32'h0000_FFFE);

        runErr("mis lh", 32'h0000_1001, 3'b001, 2'b01, 32'h0000_FFFE);
        runErr("mis lw", 32'h0000_1002, 3'b010, 2'b01, 32'h0000_FFFE);
        runErr("mis lhu", 32'h0000_1003, 3'b101, 2'b01, 32'h0000_FFFE);
        runErr("fn 011", 32'h0000_1000, 3'b011, 2'b10, 32'h0000_FFFE);
        runErr("fn prec", 32'h0000_1003, 3'b111, 2'b10, 32'h0000_FFFE);
        runErr("fn 110", 32'h0000_1000, 3'b110, 2'b10, 32'h0000_FFFE);

        // Second start and address change while REQ is waiting.
        doneBase = doneCnt;
        start = 1'b1;
        Addr  = 32'h0000_2008;
        Funct = 3'b010;
        tick();
        Addr  = 32'h0000_3000;
        Funct = 3'b000;
        tick();
        start = 1'b0;
        check("hold addr1", memIf.mem_addr, 32'h0000_2008);
        repeat (3) tick();
        check("hold addr2", memIf.mem_addr, 32'h0000_2008);
        check("hold req", 32'(memIf.mem_req), 32'd1);
        check("hold nodone", 32'(done), 32'd0);
        memIf.mem_ack   = 1'b1;
        memIf.mem_rdata = 32'hCAFE_F00D;
        tick();
        memIf.mem_ack = 1'b0;
        check("hold data", DataOut, 32'hCAFE_F00D);
        check("hold done", 32'(done), 32'd1);
        repeat (3) tick();
        check("hold single", 32'(doneCnt - doneBase), 32'd1);
        check("hold idle", 32'(busy), 32'd0);

        // Reset in the middle of REQ discards the load.
        start = 1'b1;
        Addr  = 32'h0000_4004;
        Funct = 3'b010;
        tick();
        start = 1'b0;
        check("mrst req", 32'(memIf.mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst req0", 32'(memIf.mem_req), 32'd0);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst done", 32'(done), 32'd0);
        check("mrst addr", memIf.mem_addr, 32'h0);
        check("mrst data", DataOut, 32'h0);
        doneBase = doneCnt;
        memIf.mem_ack   = 1'b1;
        memIf.mem_rdata = 32'h1111_2222;
        tick();
        memIf.mem_ack = 1'b0;
        repeat (2) tick();
        check("mrst nodone", 32'(doneCnt - doneBase), 32'd0);
        check("mrst data2", DataOut, 32'h0);

        runLoad("lw2", 32'h0000_5000, 3'b010, 32'h0BAD_F00D, 0, 32'h0BAD_F00D);

        // No ack: watchdog fires after 4 REQ cycles, or the unit waits.
        start = 1'b1;
        Addr  = 32'h0000_6000;
        Funct = 3'b010;
        tick();
        start = 1'b0;
`ifdef LOAD_TIMEOUT_EN
        repeat (3) tick();
        check("tmo req4", 32'(memIf.mem_req), 32'd1);
        tick();
        check("tmo done", 32'(done), 32'd1);
        check("tmo err", 32'(ErrCode), 32'd3);
        check("tmo req0", 32'(memIf.mem_req), 32'd0);
        check("tmo data", DataOut, 32'h0BAD_F00D);
        tick();
        check("tmo idle", 32'(busy | done), 32'd0);
`else
        repeat (20) tick();
        check("wait busy", 32'(busy), 32'd1);
        check("wait req", 32'(memIf.mem_req), 32'd1);
        check("wait nodone", 32'(done), 32'd0);
        memIf.mem_ack   = 1'b1;
        memIf.mem_rdata = 32'h7777_8888;
        tick();
        memIf.mem_ack = 1'b0;
        check("wait done", 32'(done), 32'd1);
        check("wait data", DataOut, 32'h7777_8888);
        tick();
        check("wait idle", 32'(busy | done), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
